// File: rtl/fix_pkg.sv
// Shared constants and types for the FIX field assembly stage.
package fix_pkg;

    localparam logic [7:0] FIX_SOH = 8'h01;
    localparam logic [7:0] FIX_SEP = 8'h3D;
    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_9 = 8'h39;

    // Field error flags, MSB first: {drop_prev, val_trunc, tag_ovf, tag_nondigit}
    typedef struct packed {
        logic drop_prev;
        logic val_trunc;
        logic tag_ovf;
        logic tag_nondigit;
    } field_err_t;

    typedef enum logic {
        S_TAG = 1'b0,
        S_VAL = 1'b1
    } fld_state_e;

endpackage

// File: rtl/fix_fld_outreg.sv
// One-entry valid/ready holding register for completed field records.
// A record offered while the held one is stalled is dropped and counted.
module fix_fld_outreg
    import fix_pkg::*;
#(
    parameter int unsigned TAG_W = 16,
    parameter int unsigned LEN_W = 6,
    parameter int unsigned VAL_W = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             emit_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [VAL_W-1:0] val_i,
    input  field_err_t       err_i,
    input  logic             fld_ready_i,
    output logic             fld_valid_o,
    output logic [TAG_W-1:0] fld_tag_o,
    output logic [LEN_W-1:0] fld_len_o,
    output logic [VAL_W-1:0] fld_val_o,
    output logic [3:0]       fld_err_o,
    output logic [15:0]      drop_cnt_o
);

    logic             valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [LEN_W-1:0] len_q;
    logic [VAL_W-1:0] val_q;
    field_err_t       err_q;
    logic [15:0]      drop_cnt_q;
    logic             drop_pend_q;
    logic             load;
    logic             drop;

    assign load = emit_i & (~valid_q | fld_ready_i);
    assign drop = emit_i & valid_q & ~fld_ready_i;

    // Holding register, drop counter and pending drop marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            tag_q       <= '0;
            len_q       <= '0;
            val_q       <= '0;
            err_q       <= '0;
            drop_cnt_q  <= '0;
            drop_pend_q <= 1'b0;
        end else begin
            if (load) begin
                valid_q         <= 1'b1;
                tag_q           <= tag_i;
                len_q           <= len_i;
                val_q           <= val_i;
                err_q           <= err_i;
                err_q.drop_prev <= drop_pend_q;
                drop_pend_q     <= 1'b0;
            end else if (valid_q && fld_ready_i) begin
                valid_q <= 1'b0;
            end
            if (drop) begin
                drop_pend_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end
        end
    end

    assign fld_valid_o = valid_q;
    assign fld_tag_o   = tag_q;
    assign fld_len_o   = len_q;
    assign fld_val_o   = val_q;
    assign fld_err_o   = err_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: rtl/fix_field_assembler.sv
// Builds {tag, len, value, err} field records from tokenizer strobes.
// Tag digits are accumulated to binary; value bytes are buffered up to MAX_VAL_LEN.
module fix_field_assembler
    import fix_pkg::*;
#(
    parameter int unsigned TAG_W       = 16,
    parameter int unsigned MAX_VAL_LEN = 32,
    parameter int unsigned LEN_W       = $clog2(MAX_VAL_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               data_i,
    input  logic                     tag_s_i,
    input  logic                     tag_e_i,
    input  logic                     value_s_i,
    input  logic                     value_e_i,
    output logic                     fld_valid_o,
    input  logic                     fld_ready_i,
    output logic [TAG_W-1:0]         fld_tag_o,
    output logic [LEN_W-1:0]         fld_len_o,
    output logic [8*MAX_VAL_LEN-1:0] fld_val_o,
    output logic [3:0]               fld_err_o,
    output logic [15:0]              drop_cnt_o
);

    localparam int unsigned ACC_W = TAG_W + 4;
    localparam int unsigned VAL_W = 8 * MAX_VAL_LEN;
    localparam logic [ACC_W-1:0] TAG_MAX = {4'b0000, {TAG_W{1'b1}}};

    fld_state_e       state_q;
    logic [ACC_W-1:0] acc_q;
    logic [LEN_W-1:0] len_q;
    logic [VAL_W-1:0] val_q;
    logic             nondigit_q;
    logic             ovf_q;
    logic             trunc_q;
    logic             seen_digit_q;

    logic             is_digit;
    logic [ACC_W-1:0] acc_mac;
    logic             len_full;
    logic [7:0]       val_byte;
    field_err_t       rec_err;

    // Headroom of 4 bits means acc*10+9 cannot wrap before the saturation test.
    assign is_digit = (data_i >= ASCII_0) && (data_i <= ASCII_9);
    assign acc_mac  = acc_q * ACC_W'(10) + ACC_W'(data_i - ASCII_0);
    assign len_full = (len_q == LEN_W'(MAX_VAL_LEN));
    // An '=' seen while in the value is a literal value byte.
    assign val_byte = tag_e_i ? FIX_SEP : data_i;

    // Record offered to the output stage on SOH; missing '=' counts as a bad tag.
    always_comb begin
        rec_err              = '0;
        rec_err.tag_nondigit = nondigit_q | (state_q == S_TAG);
        rec_err.tag_ovf      = ovf_q;
        rec_err.val_trunc    = trunc_q;
    end

    // Field parser: tag accumulation, value buffering, clear on SOH.
    always_ff @(posedge clk) begin
        if (rst || value_e_i) begin
            state_q      <= S_TAG;
            acc_q        <= '0;
            len_q        <= '0;
            val_q        <= '0;
            nondigit_q   <= 1'b0;
            ovf_q        <= 1'b0;
            trunc_q      <= 1'b0;
            seen_digit_q <= 1'b0;
        end else if (state_q == S_TAG) begin
            if (tag_e_i) begin
                state_q <= S_VAL;
                if (!seen_digit_q) begin
                    nondigit_q <= 1'b1;
                end
            end else if (tag_s_i) begin
                if (is_digit) begin
                    seen_digit_q <= 1'b1;
                    if (acc_mac > TAG_MAX) begin
                        acc_q <= TAG_MAX;
                        ovf_q <= 1'b1;
                    end else begin
                        acc_q <= acc_mac;
                    end
                end else begin
                    nondigit_q <= 1'b1;
                end
            end
        end else if (tag_e_i || value_s_i) begin
            if (!len_full) begin
                val_q <= val_q | (VAL_W'(val_byte) << {len_q, 3'b000});
                len_q <= len_q + LEN_W'(1);
            end else begin
                trunc_q <= 1'b1;
            end
        end
    end

    fix_fld_outreg #(
        .TAG_W (TAG_W),
        .LEN_W (LEN_W),
        .VAL_W (VAL_W)
    ) u_outreg (
        .clk         (clk),
        .rst         (rst),
        .emit_i      (value_e_i),
        .tag_i       (acc_q[TAG_W-1:0]),
        .len_i       (len_q),
        .val_i       (val_q),
        .err_i       (rec_err),
        .fld_ready_i (fld_ready_i),
        .fld_valid_o (fld_valid_o),
        .fld_tag_o   (fld_tag_o),
        .fld_len_o   (fld_len_o),
        .fld_val_o   (fld_val_o),
        .fld_err_o   (fld_err_o),
        .drop_cnt_o  (drop_cnt_o)
    );

endmodule

// File: tb/tb_fix_field_assembler.sv
// Randomized scoreboard bench for fix_field_assembler.
module tb_fix_field_assembler;

    localparam int TAG_W = 16;
    localparam int MAXV  = 32;
    localparam int LEN_W = 6;
    localparam int VAL_W = 8 * MAXV;

    typedef logic [7:0] u8;
    typedef u8 bq_t[$];
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [LEN_W-1:0] len;
        logic [VAL_W-1:0] val;
        logic [3:0]       err;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       data_i;
    logic             tag_s_i, tag_e_i, value_s_i, value_e_i;
    logic             fld_valid_o, fld_ready_i;
    logic [TAG_W-1:0] fld_tag_o;
    logic [LEN_W-1:0] fld_len_o;
    logic [VAL_W-1:0] fld_val_o;
    logic [3:0]       fld_err_o;
    logic [15:0]      drop_cnt_o;

    rec_t exp_q[$];
    rec_t cur_exp;
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
    bit   occ_m = 0;      // model: output slot holds an unaccepted record
    bit   pend_m = 0;     // model: a drop awaits reporting
    int   drop_m = 0;

    always #5 clk = ~clk;

    fix_field_assembler #(
        .TAG_W       (TAG_W),
        .MAX_VAL_LEN (MAXV),
        .LEN_W       (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .tag_s_i     (tag_s_i),
        .tag_e_i     (tag_e_i),
        .value_s_i   (value_s_i),
        .value_e_i   (value_e_i),
        .fld_valid_o (fld_valid_o),
        .fld_ready_i (fld_ready_i),
        .fld_tag_o   (fld_tag_o),
        .fld_len_o   (fld_len_o),
        .fld_val_o   (fld_val_o),
        .fld_err_o   (fld_err_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    task automatic check(input string name, input logic [VAL_W-1:0] act,
                         input logic [VAL_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(u8'(s[i]));
        return q;
    endfunction

    // Monitor: every accepted record is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && fld_valid_o && fld_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: got tag %0d with no record expected", fld_tag_o);
            end else begin
                rec_t e;
                e = exp_q.pop_front();
                if (!e.err[0]) check("rec_tag", VAL_W'(fld_tag_o), VAL_W'(e.tag));
                check("rec_len", VAL_W'(fld_len_o), VAL_W'(e.len));
                check("rec_val", fld_val_o, e.val);
                check("rec_err", VAL_W'(fld_err_o), VAL_W'(e.err));
            end
        end
    end

    // One clock of stimulus; the handshake model decides load vs drop at this edge.
    task automatic cyc(input u8 d, input logic ts, input logic te, input logic vs,
                       input logic ve);
        logic rdy;
        rec_t e;
        rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        data_i = d; tag_s_i = ts; tag_e_i = te; value_s_i = vs; value_e_i = ve;
        fld_ready_i = rdy;
        if (ve) begin
            if (!occ_m || rdy) begin
                e = cur_exp;
                e.err[3] = pend_m;
                exp_q.push_back(e);
                occ_m = 1;
                pend_m = 0;
            end else begin
                if (drop_m < 65535) drop_m++;
                pend_m = 1;
            end
        end else if (occ_m && rdy) begin
            occ_m = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(8'h00, 0, 0, 0, 0);
    endtask

    // Expected record comes from the whole tag/value strings.
    task automatic send_field(input bq_t tq, input bq_t vq, input bit has_eq, input bit soh);
        int unsigned v = 0;
        bit ovf = 0, nd = 0, seen = 0, trunc;
        rec_t e;
        foreach (tq[i]) begin
            if (tq[i] >= "0" && tq[i] <= "9") begin
                seen = 1;
                v = v * 10 + (tq[i] - 8'h30);
                if (v > 65535) begin v = 65535; ovf = 1; end
            end else nd = 1;
        end
        if (!has_eq || !seen) nd = 1;
        e.tag = v[TAG_W-1:0];
        e.len = (has_eq && vq.size() > MAXV) ? LEN_W'(MAXV) : has_eq ? LEN_W'(vq.size()) : '0;
        e.val = '0;
        for (int i = 0; i < int'(e.len); i++) e.val[i*8 +: 8] = vq[i];
        trunc = has_eq && (vq.size() > MAXV);
        e.err = {1'b0, trunc, ovf, nd};
        cur_exp = e;
        foreach (tq[i]) cyc(tq[i], 1, 0, 0, 0);
        if (has_eq) begin
            cyc(8'h3D, 0, 1, 0, 0);
            foreach (vq[i]) begin
                if (vq[i] == 8'h3D) cyc(8'h3D, 0, 1, 0, 0);
                else cyc(vq[i], 0, 0, 1, 0);
            end
        end
        if (soh) cyc(8'h01, 0, 0, 0, 1);
    endtask

    task automatic drain();
        rdy_mode = 0;
        for (int i = 0; i < 50 && (exp_q.size() != 0 || fld_valid_o); i++) idle();
        check("drain_empty", VAL_W'(exp_q.size()), '0);
    endtask

    task automatic do_reset();
        rst = 1;
        data_i = 0; tag_s_i = 0; tag_e_i = 0; value_s_i = 0; value_e_i = 0;
        fld_ready_i = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        occ_m = 0; pend_m = 0; drop_m = 0;
        exp_q.delete();
    endtask

    initial begin
        bq_t tq, vq;
        do_reset();
        check("reset_valid", VAL_W'(fld_valid_o), '0);
        check("reset_tag", VAL_W'(fld_tag_o), '0);
        check("reset_len", VAL_W'(fld_len_o), '0);
        check("reset_val", fld_val_o, '0);
        check("reset_err", VAL_W'(fld_err_o), '0);
        check("reset_drop", VAL_W'(drop_cnt_o), '0);

        // Basic field with 1-cycle latency
        rdy_mode = 0;
        send_field(s2q("35"), s2q("D"), 1, 1);
        check("latency_valid", VAL_W'(fld_valid_o), VAL_W'(1));
        check("latency_tag", VAL_W'(fld_tag_o), VAL_W'(35));
        drain();

        // Tag overflow, non-digit tag, empty tag, empty value, '=' in value, no '='
        send_field(s2q("9999999"), s2q("x"), 1, 1);
        send_field(s2q("3A"), s2q("x"), 1, 1);
        send_field(s2q(""), s2q("v"), 1, 1);
        send_field(s2q("5"), s2q(""), 1, 1);
        send_field(s2q("58"), s2q("a=b"), 1, 1);
        vq.delete();
        send_field(s2q("77"), vq, 0, 1);
        drain();

        // 40-byte value is truncated to 32
        vq.delete();
        for (int i = 0; i < 40; i++) vq.push_back(u8'($urandom_range(33, 126)));
        send_field(s2q("55"), vq, 1, 1);
        drain();

        // Backpressure drops
        rdy_mode = 2;
        send_field(s2q("1"), s2q("a"), 1, 1);
        send_field(s2q("2"), s2q("b"), 1, 1);
        send_field(s2q("3"), s2q("c"), 1, 1);
        check("bp_drop_cnt", VAL_W'(drop_cnt_o), VAL_W'(2));
        check("bp_held_tag", VAL_W'(fld_tag_o), VAL_W'(1));
        rdy_mode = 0;
        send_field(s2q("4"), s2q("d"), 1, 1);
        drain();

        // Back-to-back fields
        send_field(s2q("8"), s2q("A"), 1, 1);
        send_field(s2q("9"), s2q("B"), 1, 1);
        drain();
        check("b2b_drop_cnt", VAL_W'(drop_cnt_o), VAL_W'(drop_m));

        // Reset mid-field discards the partial field
        send_field(s2q("10"), s2q("12"), 1, 0);
        do_reset();
        idle();
        check("midrst_valid", VAL_W'(fld_valid_o), '0);
        check("midrst_drop", VAL_W'(drop_cnt_o), '0);
        send_field(s2q("1"), s2q("Z"), 1, 1);
        drain();

        // Random traffic with random backpressure
        rdy_mode = 1;
        for (int n = 0; n < 200; n++) begin
            bit has_eq;
            tq.delete();
            vq.delete();
            for (int i = 0, k = $urandom_range(1, 7); i < k; i++)
                tq.push_back(($urandom_range(0, 15) == 0) ? 8'h41 : u8'($urandom_range(48, 57)));
            has_eq = ($urandom_range(0, 19) != 0);
            if (has_eq)
                for (int i = 0, k = $urandom_range(0, 40); i < k; i++)
                    vq.push_back(u8'($urandom_range(32, 126)));
            send_field(tq, vq, has_eq, 1);
            if ($urandom_range(0, 3) == 0) idle();
        end
        check("rand_drop_cnt", VAL_W'(drop_cnt_o), VAL_W'(drop_m));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
